// File: rtl/debounce_pkg.sv
// ============================================================================
//  Module   : debounce_pkg
//  Purpose  : Shared constants and elaboration helpers for the input
//             conditioning block (synchronizer chain + debounce counters).
//  Contents : MIN_SYNC_STAGES  - shortest chain accepted for metastability
//             cnt_width(n)     - debounce counter width, max(1, $clog2(n))
//             params_ok(s, n)  - parameter legality test used at elaboration
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package debounce_pkg;

  localparam int MIN_SYNC_STAGES = 2;

  // Counter only ever holds 0..n-1, so $clog2(n) bits suffice; n=1 still
  // needs a one-bit register to keep the datapath legal.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic bit params_ok(input int sync_stages, input int debounce_cycles);
    return (sync_stages >= MIN_SYNC_STAGES) && (debounce_cycles >= 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/debounce_synchronizer_sync_chain.sv
// ============================================================================
//  Module   : sync_chain
//  Purpose  : WIDTH-bit multi-flop synchronizer; each bit is an independent
//             shift chain of STAGES flops, the last stage drives q.
//  Ports    : clk   - destination clock
//             reset - asynchronous active-low clear of every stage
//             d     - raw asynchronous inputs
//             q     - synchronized outputs (last stage)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_chain
  import debounce_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int STAGES = MIN_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < STAGES; k++) begin
        stage[k] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int k = 1; k < STAGES; k++) begin
        stage[k] <= stage[k-1];
      end
    end
  end

  assign q = stage[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/debounce_synchronizer.sv
// ============================================================================
//  Module   : debounce_synchronizer
//  Purpose  : Per-bit synchronizer + debounce for NUM_BITS asynchronous
//             inputs, with debounced level and single-cycle edge strobes.
//  Ports    : clk           - system clock, rising edge
//             reset         - asynchronous active-low clear of all state
//             async_input   - raw asynchronous inputs
//             sync_output   - synchronized, undebounced level
//             stable_output - debounced level
//             rise_pulse    - one-cycle strobe on stable 0->1
//             fall_pulse    - one-cycle strobe on stable 1->0
//             any_change    - registered OR of all rise/fall strobes
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_synchronizer
  import debounce_pkg::*;
#(
  parameter int NUM_BITS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_BITS-1:0] async_input,
  output logic [NUM_BITS-1:0] sync_output,
  output logic [NUM_BITS-1:0] stable_output,
  output logic [NUM_BITS-1:0] rise_pulse,
  output logic [NUM_BITS-1:0] fall_pulse,
  output logic                any_change
);

  localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  generate
    if (!params_ok(SYNC_STAGES, DEBOUNCE_CYCLES)) begin : g_bad_params
      $error("debounce_synchronizer: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
    end
  endgenerate

  sync_chain #(
    .WIDTH  (NUM_BITS),
    .STAGES (SYNC_STAGES)
  ) u_sync_chain (
    .clk   (clk),
    .reset (reset),
    .d     (async_input),
    .q     (sync_output)
  );

  // accept[i] is the next-state "stable level flips this edge" term; both the
  // per-bit strobes and any_change are registered from it so they line up.
  logic [NUM_BITS-1:0] accept;

  generate
    for (genvar i = 0; i < NUM_BITS; i++) begin : g_chan
      logic [CNT_W-1:0] cnt;
      logic             stable_q;
      logic             rise_q;
      logic             fall_q;

      assign accept[i] = (sync_output[i] != stable_q) && (cnt == CNT_LAST);

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cnt      <= '0;
          stable_q <= 1'b0;
          rise_q   <= 1'b0;
          fall_q   <= 1'b0;
        end else begin
          rise_q <= 1'b0;
          fall_q <= 1'b0;
          if (sync_output[i] == stable_q) begin
            // Any sample agreeing with the accepted level restarts the run.
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            cnt      <= '0;
            stable_q <= sync_output[i];
            rise_q   <= sync_output[i];
            fall_q   <= ~sync_output[i];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      end

      assign stable_output[i] = stable_q;
      assign rise_pulse[i]    = rise_q;
      assign fall_pulse[i]    = fall_q;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      any_change <= 1'b0;
    end else begin
      any_change <= |accept;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_debounce_synchronizer.sv
`default_nettype none

module tb_debounce_synchronizer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] in_a = 4'h0;
  logic [3:0] in_b = 4'h0;

  logic [3:0] sync_a, stable_a, rise_a, fall_a;
  logic       any_a;
  logic [3:0] sync_b, stable_b, rise_b, fall_b;
  logic       any_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  debounce_synchronizer #(
    .NUM_BITS(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)
  ) dut_a (
    .clk(clk), .reset(reset), .async_input(in_a),
    .sync_output(sync_a), .stable_output(stable_a),
    .rise_pulse(rise_a), .fall_pulse(fall_a), .any_change(any_a)
  );

  debounce_synchronizer #(
    .NUM_BITS(4), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1)
  ) dut_b (
    .clk(clk), .reset(reset), .async_input(in_b),
    .sync_output(sync_b), .stable_output(stable_b),
    .rise_pulse(rise_b), .fall_pulse(fall_b), .any_change(any_b)
  );

  // ---------------------------------------------------------------------
  // Reference model: sync is the input delayed by S edges; a new level is
  // accepted when the last N sampled sync values all disagree with the
  // current stable level (history cleared by reset).
  // ---------------------------------------------------------------------
  int         SS [2] = '{2, 3};
  int         NN [2] = '{4, 1};
  logic [3:0] pipe_m [2][8];
  logic [3:0] hist_m [2][8];
  int         hlen   [2];
  logic [3:0] st_m [2];
  logic [3:0] ri_m [2];
  logic [3:0] fa_m [2];
  logic       an_m [2];

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 8; k++) begin
        pipe_m[c][k] = 4'h0;
        hist_m[c][k] = 4'h0;
      end
      hlen[c] = 0;
      st_m[c] = 4'h0;
      ri_m[c] = 4'h0;
      fa_m[c] = 4'h0;
      an_m[c] = 1'b0;
    end
  endtask

  task automatic model_edge(input int c, input logic [3:0] din);
    logic [3:0] s;
    logic [3:0] flip;
    bit         all_diff;
    s = pipe_m[c][SS[c]-1];
    for (int k = NN[c] - 1; k > 0; k--) hist_m[c][k] = hist_m[c][k-1];
    hist_m[c][0] = s;
    if (hlen[c] < NN[c]) hlen[c]++;
    flip = 4'h0;
    for (int b = 0; b < 4; b++) begin
      if (hlen[c] == NN[c]) begin
        all_diff = 1'b1;
        for (int k = 0; k < NN[c]; k++)
          if (hist_m[c][k][b] == st_m[c][b]) all_diff = 1'b0;
        flip[b] = all_diff;
      end
    end
    ri_m[c] = flip & ~st_m[c];
    fa_m[c] = flip & st_m[c];
    an_m[c] = |flip;
    st_m[c] = st_m[c] ^ flip;
    for (int k = SS[c] - 1; k > 0; k--) pipe_m[c][k] = pipe_m[c][k-1];
    pipe_m[c][0] = din;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_reset();
    end else begin
      model_edge(0, in_a);
      model_edge(1, in_b);
    end
  end

  // ---------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic check_a(input string tag, input logic [3:0] s, input logic [3:0] st,
                         input logic [3:0] r, input logic [3:0] f, input logic a);
    check({tag, ".sync"},   32'(sync_a),   32'(s));
    check({tag, ".stable"}, 32'(stable_a), 32'(st));
    check({tag, ".rise"},   32'(rise_a),   32'(r));
    check({tag, ".fall"},   32'(fall_a),   32'(f));
    check({tag, ".any"},    32'(any_a),    32'(a));
  endtask

  task automatic step_a(input logic [3:0] v);
    in_a = v;
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input logic [3:0] v);
    in_b = v;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] din;
    logic [3:0] sync;
    logic [3:0] stable;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       any;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [3:0] d, input logic [3:0] s, input logic [3:0] st,
                              input logic [3:0] r, input logic [3:0] f, input logic a);
    vec_t v;
    v.din = d; v.sync = s; v.stable = st; v.rise = r; v.fall = f; v.any = a;
    vecs.push_back(v);
  endfunction

  initial begin
    // Clean rise on bit0: sync after edge 2, stable + rise after edge 6.
    add(4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    add(4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0);
    add(4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0);
    add(4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0);
    add(4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0);
    add(4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 1'b1);
    add(4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 1'b0);
    // Bit1 high for 3 synchronized cycles: rejected.
    add(4'h3, 4'h1, 4'h1, 4'h0, 4'h0, 1'b0);
    add(4'h3, 4'h3, 4'h1, 4'h0, 4'h0, 1'b0);
    add(4'h3, 4'h3, 4'h1, 4'h0, 4'h0, 1'b0);
    add(4'h1, 4'h3, 4'h1, 4'h0, 4'h0, 1'b0);
    add(4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 1'b0);
    // Bit1 held high: accepted after 4 synchronized samples.
    add(4'h3, 4'h1, 4'h1, 4'h0, 4'h0, 1'b0);
    add(4'h3, 4'h3, 4'h1, 4'h0, 4'h0, 1'b0);
    add(4'h3, 4'h3, 4'h1, 4'h0, 4'h0, 1'b0);
    add(4'h3, 4'h3, 4'h1, 4'h0, 4'h0, 1'b0);
    add(4'h3, 4'h3, 4'h1, 4'h0, 4'h0, 1'b0);
    add(4'h3, 4'h3, 4'h3, 4'h2, 4'h0, 1'b1);
    add(4'h3, 4'h3, 4'h3, 4'h0, 4'h0, 1'b0);
    // Raise bit3, then drop bits 0 and 3 together.
    add(4'hB, 4'h3, 4'h3, 4'h0, 4'h0, 1'b0);
    add(4'hB, 4'hB, 4'h3, 4'h0, 4'h0, 1'b0);
    add(4'hB, 4'hB, 4'h3, 4'h0, 4'h0, 1'b0);
    add(4'hB, 4'hB, 4'h3, 4'h0, 4'h0, 1'b0);
    add(4'hB, 4'hB, 4'h3, 4'h0, 4'h0, 1'b0);
    add(4'hB, 4'hB, 4'hB, 4'h8, 4'h0, 1'b1);
    add(4'h2, 4'hB, 4'hB, 4'h0, 4'h0, 1'b0);
    add(4'h2, 4'h2, 4'hB, 4'h0, 4'h0, 1'b0);
    add(4'h2, 4'h2, 4'hB, 4'h0, 4'h0, 1'b0);
    add(4'h2, 4'h2, 4'hB, 4'h0, 4'h0, 1'b0);
    add(4'h2, 4'h2, 4'hB, 4'h0, 4'h0, 1'b0);
    add(4'h2, 4'h2, 4'h2, 4'h0, 4'h9, 1'b1);
    add(4'h2, 4'h2, 4'h2, 4'h0, 4'h0, 1'b0);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_a("reset", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      step_a(vecs[i].din);
      check_a($sformatf("vec%0d", i), vecs[i].sync, vecs[i].stable,
              vecs[i].rise, vecs[i].fall, vecs[i].any);
    end

    // Asynchronous reset asserted between edges clears everything at once.
    repeat (6) step_a(4'hF);
    #3 reset = 1'b0;
    #1;
    check_a("async_rst", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_a("rst_held", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);

    // Reset mid-count on bit2: a full 2+4 edges are needed after release.
    in_a  = 4'h4;
    reset = 1'b1;
    repeat (4) step_a(4'h4);
    check("midcnt.pre", 32'(stable_a), 32'h0);
    #3 reset = 1'b0;
    #1;
    check("midcnt.rst_sync", 32'(sync_a), 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step_a(4'h4);
      if (k < 6) begin
        check($sformatf("midcnt.e%0d.rise", k), 32'(rise_a), 32'h0);
        check($sformatf("midcnt.e%0d.stable", k), 32'(stable_a), 32'h0);
      end else begin
        check("midcnt.e6.rise", 32'(rise_a), 32'h4);
        check("midcnt.e6.any", 32'(any_a), 32'h1);
        check("midcnt.e6.stable", 32'(stable_a), 32'h4);
      end
    end

    // SYNC_STAGES=3, DEBOUNCE_CYCLES=1 instance.
    step_b(4'h1);
    step_b(4'h1);
    step_b(4'h1);
    check("b.e3.sync", 32'(sync_b), 32'h1);
    check("b.e3.stable", 32'(stable_b), 32'h0);
    step_b(4'h1);
    check("b.e4.stable", 32'(stable_b), 32'h1);
    check("b.e4.rise", 32'(rise_b), 32'h1);
    check("b.e4.any", 32'(any_b), 32'h1);
    step_b(4'h3);                       // one-cycle glitch on bit1
    step_b(4'h1);
    step_b(4'h1);
    check("b.e7.sync", 32'(sync_b), 32'h3);
    check("b.e7.stable", 32'(stable_b), 32'h1);
    step_b(4'h1);
    check("b.e8.stable", 32'(stable_b), 32'h3);
    check("b.e8.rise", 32'(rise_b), 32'h2);
    check("b.e8.any", 32'(any_b), 32'h1);
    step_b(4'h1);
    check("b.e9.stable", 32'(stable_b), 32'h1);
    check("b.e9.fall", 32'(fall_b), 32'h2);
    check("b.e9.rise", 32'(rise_b), 32'h0);
    check("b.e9.any", 32'(any_b), 32'h1);
    step_b(4'h1);
    check("b.e10.fall", 32'(fall_b), 32'h0);
    check("b.e10.any", 32'(any_b), 32'h0);

    // Randomized stimulus against the reference model, both instances.
    for (int n = 0; n < 600; n++) begin
      logic [3:0] fa, fb;
      for (int b = 0; b < 4; b++) begin
        fa[b] = ($urandom_range(0, 5) == 0);
        fb[b] = ($urandom_range(0, 2) == 0);
      end
      in_a = in_a ^ fa;
      in_b = in_b ^ fb;
      if ($urandom_range(0, 99) == 0) begin
        #2 reset = 1'b0;
        #2 reset = 1'b1;
      end
      @(posedge clk);
      #1;
      check("rnd.a.sync",   32'(sync_a),   32'(pipe_m[0][SS[0]-1]));
      check("rnd.a.stable", 32'(stable_a), 32'(st_m[0]));
      check("rnd.a.rise",   32'(rise_a),   32'(ri_m[0]));
      check("rnd.a.fall",   32'(fall_a),   32'(fa_m[0]));
      check("rnd.a.any",    32'(any_a),    32'(an_m[0]));
      check("rnd.b.sync",   32'(sync_b),   32'(pipe_m[1][SS[1]-1]));
      check("rnd.b.stable", 32'(stable_b), 32'(st_m[1]));
      check("rnd.b.rise",   32'(rise_b),   32'(ri_m[1]));
      check("rnd.b.fall",   32'(fall_b),   32'(fa_m[1]));
      check("rnd.b.any",    32'(any_b),    32'(an_m[1]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/debounce_synchronizer.md
# debounce_synchronizer

Parametrised input-conditioning block for multiple asynchronous inputs, such as keypad columns and pushbuttons. Each input bit passes through a configurable-depth synchronizer chain and then an independent debounce counter. Per bit, the block produces a debounced level plus single-cycle rise and fall strobes. It sits between the FPGA input pins and the scanning/decoding FSMs, and replaces the fixed two-flop synchronizer.

## Interface
Parameters:
- NUM_BITS, 4, number of independent input channels (≥1)
- SYNC_STAGES, 2, flip-flops per synchronizer chain (≥2)
- DEBOUNCE_CYCLES, 16, consecutive stable samples required to accept a new level (≥1)

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- reset  input  1  asynchronous, active-low reset; reset asserted (0) clears all state immediately, independent of clk
- async_input  input  NUM_BITS  raw asynchronous inputs
- sync_output  output  NUM_BITS  synchronized, undebounced level (last stage of each chain)
- stable_output  output  NUM_BITS  debounced level
- rise_pulse  output  NUM_BITS  one-cycle strobe when stable_output[i] goes 0→1
- fall_pulse  output  NUM_BITS  one-cycle strobe when stable_output[i] goes 1→0
- any_change  output  1  registered OR of all rise_pulse and fall_pulse bits

## Operation
- Reset (reset==0): every synchronizer stage, counter, stable_output, rise_pulse, fall_pulse and any_change is set to 0. The effect is immediate and does not wait for a clock edge.
- Synchronizer: per bit, a shift chain of SYNC_STAGES flops. sync_output is the last stage.
- Debounce, per bit i, with counter cnt[i] and N = DEBOUNCE_CYCLES:
  - If sync_output[i] == stable_output[i]: cnt[i] ← 0.
  - Else if cnt[i] == N−1: stable_output[i] ← sync_output[i] and cnt[i] ← 0. The matching rise_pulse or fall_pulse bit is 1 for that cycle.
  - Else: cnt[i] ← cnt[i]+1.
- Any sample that matches the stable level restarts the count. Acceptance therefore requires N consecutive mismatching samples.
- Pulses are registered. Each is high for exactly one cycle, coincident with the stable_output change. Otherwise pulses are 0.
- any_change is registered and asserts in the same cycle as the pulses: it is computed from the same next-state terms, not from the registered pulses.
- Channels are fully independent. Simultaneous changes on several bits produce simultaneous pulses and a single any_change cycle.
- Counter width: $clog2(N) bits, with a minimum of 1. Compare against N−1; the counter never wraps past N−1.
- N=1: stable_output follows sync_output with one cycle of delay, and every change produces a pulse.

## Timing
- The input is stable before rising edge 1. sync_output changes after edge SYNC_STAGES.
- stable_output and its pulse change after edge SYNC_STAGES+N. The pulse deasserts after edge SYNC_STAGES+N+1.
- A glitch must be shorter than N synchronized cycles to be rejected. A pulse lasting exactly N cycles at the sync_output is accepted.
- Reset released mid-count: all counters are at 0, and a full N samples are needed after release.
- Reset deassertion is asynchronous to clk. The reset driver provides a synchronized release; this block does not resynchronize it.
- No throughput limit: the fastest possible stable toggle rate is one change per N cycles per bit.

## Structure
- Package debounce_pkg holds:
  - MIN_SYNC_STAGES = 2
  - function cnt_width(n), returning max(1, $clog2(n))
  - elaboration-time checks that SYNC_STAGES ≥ MIN_SYNC_STAGES and DEBOUNCE_CYCLES ≥ 1
- Sub-module sync_chain: one NUM_BITS-wide chain parametrised by SYNC_STAGES, with the same clk/reset. It is instantiated once.
- The debounce counters and pulse logic live in a generate loop over NUM_BITS in the top module.

## Test plan
All scenarios use NUM_BITS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4 unless stated.
- Async reset: async_input=4'hF, drive reset=0 between clock edges. All outputs are 0 before the next edge and stay 0 while reset is held.
- Clean rise: bit0 goes 0→1 before edge 1. sync_output[0]=1 after edge 2. stable_output[0], rise_pulse[0] and any_change are 1 after edge 6. Both pulses are 0 after edge 7.
- Bounce reject: bit1 is high for 3 synchronized cycles, then low. There is no stable change and no pulse. Bit1 then held high for 4 cycles gives rise_pulse[1] exactly once.
- Fall plus simultaneous: bits 0 and 3 are stable at 1, then both drop in the same cycle. fall_pulse=4'b1001 for one cycle, any_change=1 for one cycle, stable_output=4'b0000.
- Reset mid-count: bit2 mismatch with cnt=2, then assert reset for 1 cycle. Outputs are 0. After release, bit2 still high needs 2+4 edges before rise_pulse[2].
- Parameter sweep: SYNC_STAGES=3 and DEBOUNCE_CYCLES=1. The rise is visible on stable_output after edge 4, and a single-cycle glitch on sync_output produces a rise pulse followed by a fall pulse.
